mode_output_arbiter: RTL and testbench
======================================

// Module: mode_output_arbiter
// PURPOSE
//  Registered, parametrised successor of the top-level mode selector: picks speaker/LED/display sources per mode
//  (auto, free, learning), keeps a per-user/per-song best-score table, and inserts a silent handover gap on mode change.
//  Sits between auto_player/keyboard/learning and seg_display/score2level; all outputs are flop-driven (no latches).
// PARAMETERS
//  N_USERS    4      number of user slots; USER_W = $clog2(N_USERS)
//  N_SONGS    4      number of songs; SONG_W = $clog2(N_SONGS)
//  SCORE_W    33     score width
//  MUTE_CYC   1000   clock cycles of forced silence on any mode change (>=1)
//  BLINK_DIV  25_000_000  half-period in cycles of new-record blink (only with macro)
// PORTS
//  clk        in   1              system clock
//  rst_n      in   1              asynchronous active-low reset
//  mode       in   3              011 auto, 001 free, 111 learning, other idle
//  song_num   in   SONG_W         selected song
//  user       in   USER_W         selected user
//  spk_auto   in   1              auto_player speaker
//  spk_free   in   1              keyboard speaker
//  spk_lrn    in   1              learning speaker
//  led_auto   in   8              auto_player LEDs
//  led_lrn    in   8              learning LEDs
//  finished   in   1              learning run complete (level)
//  score      in   SCORE_W        learning score, valid while finished=1
//  rec_digits in   20             4x5-bit codes from score2level of rec_score {d3,d2,d1,d0}
//  rec_score  out  SCORE_W        best score of current {user,song_num}; to score2level
//  new_record out  1              pulses 1 cycle when a commit raised the table entry
//  speaker    out  1              selected speaker
//  led        out  8              selected LEDs
//  disp       out  40             {p7..p0} 5-bit seg_display codes
// BEHAVIOUR
//  Reset (async): state=IDLE, speaker=0, led=0, new_record=0, disp={`HELLO,`EMPTY3}, all table entries=0, mute cnt=0.
//  States: IDLE, MUTE, AUTO, FREE, LEARN, RESULT. mode sampled every cycle into mode_q.
//  - Any cycle with mode != mode_q (from any state): -> MUTE, counter loads MUTE_CYC-1; speaker=0, led=0, disp={`HELLO,`EMPTY3}.
//  - MUTE: counts down; at 0 -> state decoded from current mode (011 AUTO, 001 FREE, 111 LEARN, else IDLE).
//    A further mode change during MUTE reloads the counter (gap restarts).
//  - AUTO: speaker<=spk_auto, led<=led_auto, disp={`AUTO,`EMPTY3,code(song_num)}.
//  - FREE: speaker<=spk_free, led<=0, disp={`FREE,`EMPTY4}.
//  - LEARN: speaker<=spk_lrn, led<=led_lrn, disp={`LRN,blank,rec_digits}. finished 0->1 edge -> commit, -> RESULT.
//  - Commit (single cycle): idx={user,song_num}; if score > table[idx] (unsigned): table[idx]<=score, new_record=1 next cycle;
//    equal or lower: table unchanged, new_record stays 0.
//  - RESULT: speaker<=spk_lrn, led<=0, disp={'U',code(user),'S',code(song_num),rec_digits}; finished=0 -> LEARN.
//  - IDLE: speaker=0, led=0, disp={`HELLO,`EMPTY3}.
//  Latency: source inputs to outputs = 1 clk. rec_score = table[{user,song_num}] combinational read, updates cycle after commit.
//  user/song_num change in RESULT: display and rec_score follow immediately; no commit (edge-triggered only).
//  finished already high on entering LEARN: no commit until a fresh 0->1 edge.
//  Out-of-range user/song_num (non-power-of-two counts): reads return 0, commits ignored.
// CONFIGURATION
//  NEW_RECORD_BLINK_EN defined: after a raising commit, RESULT toggles p3..p0 between rec_digits and `EMPTY4 every
//    BLINK_DIV cycles until RESULT is left; blink counter reset on entry.
//  Not defined: RESULT shows rec_digits steadily; BLINK_DIV unused.
// STRUCTURE
//  const.v (shared header): mode codes MODE_AUTO/MODE_FREE/MODE_LRN, display codes `AUTO `FREE `LRN `HELLO `EMPTY3/4,
//    glyph codes CH_U, CH_S, CH_BLANK; state encodings local to module.
//  Sub-module score_table: N_USERS*N_SONGS x SCORE_W register file, async reset clear, compare-and-write port,
//    async read port, outputs raised flag.
// TESTING
//  Reset mid-AUTO with spk_auto toggling -> speaker=0, led=0, disp=HELLO immediately; table all 0.
//  mode 000->011, song_num=2 -> speaker 0 for exactly MUTE_CYC cycles, then tracks spk_auto with 1-cycle lag, p0=2.
//  LEARN user=1 song=3: finished rise with score=500 -> table[7]=500, new_record 1-cycle pulse, disp U1S3.
//  Repeat with score=300 then 500 -> table[7] stays 500, new_record never asserts.
//  mode toggled 011->001->011 inside MUTE window -> gap restarts; silence lasts MUTE_CYC after last change.
//  With NEW_RECORD_BLINK_EN, BLINK_DIV=4 after raising commit -> p3..p0 alternate every 4 cycles; without, steady.

Source files
------------

// File: rtl/mode_output_arbiter_pkg.sv
// Shared constants for the mode output arbiter slice.
// Holds the mode codes, seg_display glyph codes and the composite display
// words used by the arbiter, plus a helper that turns a small number into
// its digit glyph. Imported by mode_output_arbiter and score_table.

package mode_output_arbiter_pkg;

    // Mode selector codes
    localparam logic [2:0] MODE_AUTO = 3'b011;
    localparam logic [2:0] MODE_FREE = 3'b001;
    localparam logic [2:0] MODE_LRN  = 3'b111;

    // seg_display glyph codes: 0..9 are the digits themselves
    localparam logic [4:0] CH_A     = 5'd10;
    localparam logic [4:0] CH_E     = 5'd11;
    localparam logic [4:0] CH_F     = 5'd12;
    localparam logic [4:0] CH_H     = 5'd13;
    localparam logic [4:0] CH_L     = 5'd14;
    localparam logic [4:0] CH_N     = 5'd15;
    localparam logic [4:0] CH_O     = 5'd16;
    localparam logic [4:0] CH_R     = 5'd17;
    localparam logic [4:0] CH_S     = 5'd18;
    localparam logic [4:0] CH_T     = 5'd19;
    localparam logic [4:0] CH_U     = 5'd20;
    localparam logic [4:0] CH_BLANK = 5'd31;

    // Composite display words, most significant glyph leftmost
    localparam logic [24:0] DISP_HELLO  = {CH_H, CH_E, CH_L, CH_L, CH_O};
    localparam logic [19:0] DISP_AUTO   = {CH_A, CH_U, CH_T, CH_O};
    localparam logic [19:0] DISP_FREE   = {CH_F, CH_R, CH_E, CH_E};
    localparam logic [14:0] DISP_LRN    = {CH_L, CH_R, CH_N};
    localparam logic [14:0] DISP_EMPTY3 = {3{CH_BLANK}};
    localparam logic [19:0] DISP_EMPTY4 = {4{CH_BLANK}};

    function automatic logic [4:0] glyph_num(input logic [3:0] v);
        return {1'b0, v};
    endfunction

endpackage

// File: rtl/mode_output_arbiter_score_table.sv
// score_table: best-score register file, one entry per {user, song}.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (clears every entry)
//   user, song   entry select shared by the read and compare-and-write ports
//   wr_en        commit request: write wr_score only if it beats the entry
//   wr_score     candidate score
//   rd_score     combinational read of the selected entry (0 if out of range)
//   raised       combinational: this commit will raise the selected entry

module score_table
    import mode_output_arbiter_pkg::*;
#(
    parameter int N_USERS = 4,
    parameter int N_SONGS = 4,
    parameter int SCORE_W = 33,
    parameter int USER_W  = 2,
    parameter int SONG_W  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [USER_W-1:0]  user,
    input  logic [SONG_W-1:0]  song,
    input  logic               wr_en,
    input  logic [SCORE_W-1:0] wr_score,
    output logic [SCORE_W-1:0] rd_score,
    output logic               raised
);

    localparam int N_ENT = N_USERS * N_SONGS;
    localparam int IDX_W = (N_ENT > 1) ? $clog2(N_ENT) : 1;
    localparam int unsigned USER_LIM = N_USERS;
    localparam int unsigned SONG_LIM = N_SONGS;

    logic [SCORE_W-1:0] tbl [N_ENT];
    logic [IDX_W-1:0]   idx;
    logic               in_range;

    // Codes beyond the configured counts exist when a count is not a power
    // of two; they must neither alias a real entry nor be written.
    assign in_range = (32'(user) < USER_LIM) && (32'(song) < SONG_LIM);
    assign idx      = IDX_W'(32'(user) * SONG_LIM + 32'(song));

    assign rd_score = in_range ? tbl[idx] : '0;
    assign raised   = wr_en && in_range && (wr_score > tbl[idx]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_ENT; i++) begin
                tbl[i] <= '0;
            end
        end else if (raised) begin
            tbl[idx] <= wr_score;
        end
    end

endmodule

// File: rtl/mode_output_arbiter.sv
// mode_output_arbiter: registered selector of speaker/LED/display sources per
// mode (auto, free, learning), with a best-score table and a silent handover
// gap of MUTE_CYC cycles on every mode change.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   mode              011 auto, 001 free, 111 learning, anything else idle
//   song_num, user    current song / user selection
//   spk_auto/free/lrn speaker sources
//   led_auto, led_lrn LED sources
//   finished, score   learning run complete (level) and its score
//   rec_digits        score2level digit codes of rec_score {d3,d2,d1,d0}
//   rec_score         best score of the current {user, song_num}
//   new_record        one-cycle pulse after a commit raised the table
//   speaker, led      selected speaker / LEDs (registered)
//   disp              {p7..p0} seg_display glyph codes (registered)
// Build option: define NEW_RECORD_BLINK_EN to blink p3..p0 in RESULT after a
// record-raising commit, toggling every BLINK_DIV cycles.

module mode_output_arbiter
    import mode_output_arbiter_pkg::*;
#(
    parameter int N_USERS   = 4,
    parameter int N_SONGS   = 4,
    parameter int SCORE_W   = 33,
    parameter int MUTE_CYC  = 1000,
    parameter int BLINK_DIV = 25_000_000,
    localparam int USER_W   = (N_USERS > 1) ? $clog2(N_USERS) : 1,
    localparam int SONG_W   = (N_SONGS > 1) ? $clog2(N_SONGS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2:0]         mode,
    input  logic [SONG_W-1:0]  song_num,
    input  logic [USER_W-1:0]  user,
    input  logic               spk_auto,
    input  logic               spk_free,
    input  logic               spk_lrn,
    input  logic [7:0]         led_auto,
    input  logic [7:0]         led_lrn,
    input  logic               finished,
    input  logic [SCORE_W-1:0] score,
    input  logic [19:0]        rec_digits,
    output logic [SCORE_W-1:0] rec_score,
    output logic               new_record,
    output logic               speaker,
    output logic [7:0]         led,
    output logic [39:0]        disp
);

    localparam int CNT_W = (MUTE_CYC > 1) ? $clog2(MUTE_CYC) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUTE,
        ST_AUTO,
        ST_FREE,
        ST_LEARN,
        ST_RESULT
    } state_t;

    state_t             state, state_nxt;
    logic [2:0]         mode_q;
    logic               fin_q;
    logic [CNT_W-1:0]   mute_cnt, mute_cnt_nxt;
    logic               mode_chg;
    logic               fin_rise;
    logic               commit;
    logic               raised;
    logic [19:0]        result_digits;

    logic               spk_nxt;
    logic [7:0]         led_nxt;
    logic [39:0]        disp_nxt;

    function automatic state_t mode_state(input logic [2:0] m);
        case (m)
            MODE_AUTO: return ST_AUTO;
            MODE_FREE: return ST_FREE;
            MODE_LRN:  return ST_LEARN;
            default:   return ST_IDLE;
        endcase
    endfunction

    assign mode_chg = (mode != mode_q);
    assign fin_rise = finished && !fin_q;

    score_table #(
        .N_USERS (N_USERS),
        .N_SONGS (N_SONGS),
        .SCORE_W (SCORE_W),
        .USER_W  (USER_W),
        .SONG_W  (SONG_W)
    ) u_table (
        .clk      (clk),
        .rst_n    (rst_n),
        .user     (user),
        .song     (song_num),
        .wr_en    (commit),
        .wr_score (score),
        .rd_score (rec_score),
        .raised   (raised)
    );

    // State register; mode and finished are sampled every cycle so change
    // and edge detection work from any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            mode_q   <= '0;
            fin_q    <= 1'b0;
            mute_cnt <= '0;
        end else begin
            state    <= state_nxt;
            mode_q   <= mode;
            fin_q    <= finished;
            mute_cnt <= mute_cnt_nxt;
        end
    end

    // Next state; a mode change overrides every other transition.
    always_comb begin
        state_nxt    = state;
        mute_cnt_nxt = mute_cnt;
        commit       = 1'b0;
        if (mode_chg) begin
            state_nxt    = ST_MUTE;
            mute_cnt_nxt = CNT_W'(MUTE_CYC - 1);
        end else begin
            case (state)
                ST_MUTE: begin
                    if (mute_cnt == '0) begin
                        state_nxt = mode_state(mode);
                    end else begin
                        mute_cnt_nxt = mute_cnt - CNT_W'(1);
                    end
                end
                ST_LEARN: begin
                    if (fin_rise) begin
                        commit    = 1'b1;
                        state_nxt = ST_RESULT;
                    end
                end
                ST_RESULT: begin
                    if (!finished) begin
                        state_nxt = ST_LEARN;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef NEW_RECORD_BLINK_EN
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_active;
    logic               blink_phase, blink_phase_nxt;
    logic               blink_blank;

    // The phase is looked ahead so the displayed half-period is exactly
    // BLINK_DIV cycles, counted from the cycle RESULT is entered.
    always_comb begin
        blink_phase_nxt = 1'b0;
        if (state == ST_RESULT) begin
            blink_phase_nxt = blink_phase;
            if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
                blink_phase_nxt = ~blink_phase;
            end
        end
    end

    assign blink_blank = (state == ST_RESULT) && blink_active && blink_phase_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt    <= '0;
            blink_active <= 1'b0;
            blink_phase  <= 1'b0;
        end else if (state_nxt != ST_RESULT) begin
            blink_cnt    <= '0;
            blink_active <= 1'b0;
            blink_phase  <= 1'b0;
        end else if (state != ST_RESULT) begin
            blink_cnt    <= '0;
            blink_active <= raised;
            blink_phase  <= 1'b0;
        end else begin
            if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end
            blink_phase <= blink_phase_nxt;
        end
    end

    assign result_digits = blink_blank ? DISP_EMPTY4 : rec_digits;
`else
    logic unused_blink;
    assign unused_blink  = (BLINK_DIV == 0);
    assign result_digits = rec_digits;
`endif

    // Outputs follow the state being entered, so silence starts on the
    // change cycle and the gap lasts exactly MUTE_CYC cycles.
    always_comb begin
        spk_nxt  = 1'b0;
        led_nxt  = '0;
        disp_nxt = {DISP_HELLO, DISP_EMPTY3};
        case (state_nxt)
            ST_AUTO: begin
                spk_nxt  = spk_auto;
                led_nxt  = led_auto;
                disp_nxt = {DISP_AUTO, DISP_EMPTY3, glyph_num(4'(song_num))};
            end
            ST_FREE: begin
                spk_nxt  = spk_free;
                disp_nxt = {DISP_FREE, DISP_EMPTY4};
            end
            ST_LEARN: begin
                spk_nxt  = spk_lrn;
                led_nxt  = led_lrn;
                disp_nxt = {DISP_LRN, CH_BLANK, rec_digits};
            end
            ST_RESULT: begin
                spk_nxt  = spk_lrn;
                disp_nxt = {CH_U, glyph_num(4'(user)), CH_S,
                            glyph_num(4'(song_num)), result_digits};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            speaker    <= 1'b0;
            led        <= '0;
            disp       <= {DISP_HELLO, DISP_EMPTY3};
            new_record <= 1'b0;
        end else begin
            speaker    <= spk_nxt;
            led        <= led_nxt;
            disp       <= disp_nxt;
            new_record <= raised;
        end
    end

endmodule

// File: tb/tb_mode_output_arbiter.sv
// Scoreboard bench for mode_output_arbiter: the stimulus process predicts each
// cycle's outputs from the behavioural rules and queues them; a monitor pops
// and compares one entry per clock.

module tb_mode_output_arbiter;
    import mode_output_arbiter_pkg::*;

    localparam int M  = 20;
    localparam int BD = 4;
    localparam int NU = 4;
    localparam int NS = 4;
    localparam int SW = 33;

    localparam int V_IDLE   = 0;
    localparam int V_MUTE   = 1;
    localparam int V_AUTO   = 2;
    localparam int V_FREE   = 3;
    localparam int V_LEARN  = 4;
    localparam int V_RESULT = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2:0]    mode;
    logic [1:0]    song_num;
    logic [1:0]    user;
    logic          spk_auto, spk_free, spk_lrn;
    logic [7:0]    led_auto, led_lrn;
    logic          finished;
    logic [SW-1:0] score;
    logic [19:0]   rec_digits;
    logic [SW-1:0] rec_score;
    logic          new_record;
    logic          speaker;
    logic [7:0]    led;
    logic [39:0]   disp;

    always #5 clk = ~clk;

    mode_output_arbiter #(
        .N_USERS   (NU),
        .N_SONGS   (NS),
        .SCORE_W   (SW),
        .MUTE_CYC  (M),
        .BLINK_DIV (BD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .song_num   (song_num),
        .user       (user),
        .spk_auto   (spk_auto),
        .spk_free   (spk_free),
        .spk_lrn    (spk_lrn),
        .led_auto   (led_auto),
        .led_lrn    (led_lrn),
        .finished   (finished),
        .score      (score),
        .rec_digits (rec_digits),
        .rec_score  (rec_score),
        .new_record (new_record),
        .speaker    (speaker),
        .led        (led),
        .disp       (disp)
    );

    typedef struct {
        logic          spk;
        logic [7:0]    led;
        logic [39:0]   disp;
        logic          nr;
        logic [SW-1:0] rec;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // reference model state
    logic [2:0]    m_prev;
    int            view;
    int            gap;
    int            age;
    bit            fin_prev;
    bit            blink;
    logic [SW-1:0] tbl [NU*NS];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [4:0] glyph_of(input byte c);
        if (c >= "0" && c <= "9") return 5'(c - "0");
        case (c)
            "A": return CH_A;
            "E": return CH_E;
            "F": return CH_F;
            "H": return CH_H;
            "L": return CH_L;
            "N": return CH_N;
            "O": return CH_O;
            "R": return CH_R;
            "S": return CH_S;
            "T": return CH_T;
            "U": return CH_U;
            default: return CH_BLANK;
        endcase
    endfunction

    // Eight-glyph display from text, p7 = first character, blanks padding.
    function automatic logic [39:0] text_disp(input string s);
        logic [39:0] d;
        byte c;
        for (int i = 0; i < 8; i++) begin
            c = (i < s.len()) ? s[i] : 8'h20;
            d[39-5*i -: 5] = glyph_of(c);
        end
        return d;
    endfunction

    function automatic int decode_view(input logic [2:0] m);
        if (m == 3'b011) return V_AUTO;
        if (m == 3'b001) return V_FREE;
        if (m == 3'b111) return V_LEARN;
        return V_IDLE;
    endfunction

    // Predict the outputs after the coming rising edge from the inputs now
    // applied, queue them, then advance to the next falling edge.
    task automatic step();
        exp_t e;
        int   idx;
        logic [39:0] d;
        e.nr = 1'b0;
        if (mode != m_prev) begin
            view = V_MUTE;
            gap  = M;
        end
        m_prev = mode;
        if (view == V_MUTE) begin
            if (gap == 0) view = decode_view(mode);
            else gap--;
        end else if (view == V_LEARN && finished && !fin_prev) begin
            idx = int'(user) * NS + int'(song_num);
            if (score > tbl[idx]) begin
                tbl[idx] = score;
                e.nr     = 1'b1;
                blink    = 1'b1;
            end else begin
                blink = 1'b0;
            end
            view = V_RESULT;
            age  = 0;
        end else if (view == V_RESULT) begin
            if (!finished) view = V_LEARN;
            else age++;
        end
        fin_prev = finished;

        e.spk  = 1'b0;
        e.led  = 8'h00;
        e.disp = text_disp("HELLO");
        case (view)
            V_AUTO: begin
                e.spk  = spk_auto;
                e.led  = led_auto;
                e.disp = text_disp($sformatf("AUTO   %0d", song_num));
            end
            V_FREE: begin
                e.spk  = spk_free;
                e.disp = text_disp("FREE");
            end
            V_LEARN: begin
                e.spk  = spk_lrn;
                e.led  = led_lrn;
                d = text_disp("LRN");
                e.disp = {d[39:20], rec_digits};
            end
            V_RESULT: begin
                e.spk = spk_lrn;
                d = text_disp($sformatf("U%0dS%0d", user, song_num));
                e.disp = {d[39:20], rec_digits};
`ifdef NEW_RECORD_BLINK_EN
                if (blink && ((age / BD) % 2 == 1)) e.disp[19:0] = {4{CH_BLANK}};
`endif
            end
            default: ;
        endcase
        e.rec = tbl[int'(user) * NS + int'(song_num)];
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic rand_src();
        spk_auto   = 1'($urandom);
        spk_free   = 1'($urandom);
        spk_lrn    = 1'($urandom);
        led_auto   = 8'($urandom);
        led_lrn    = 8'($urandom);
        rec_digits = 20'($urandom);
    endtask

    task automatic run(input int n);
        repeat (n) begin
            rand_src();
            step();
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_speaker"}, 64'(speaker), 64'(0));
        chk({tag, "_led"}, 64'(led), 64'(0));
        chk({tag, "_disp"}, 64'(disp), 64'(text_disp("HELLO")));
        chk({tag, "_new_record"}, 64'(new_record), 64'(0));
        for (int u = 0; u < NU; u++) begin
            for (int s = 0; s < NS; s++) begin
                user     = 2'(u);
                song_num = 2'(s);
                #1;
                chk($sformatf("%s_table_u%0ds%0d", tag, u, s), 64'(rec_score), 64'(0));
            end
        end
    endtask

    // monitor
    always begin
        @(posedge clk);
        #1;
        if (rst_n && q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("speaker", 64'(speaker), 64'(e.spk));
            chk("led", 64'(led), 64'(e.led));
            chk("disp", 64'(disp), 64'(e.disp));
            chk("new_record", 64'(new_record), 64'(e.nr));
            chk("rec_score", 64'(rec_score), 64'(e.rec));
        end
    end

    initial begin
        logic [2:0] modes [6];
        modes[0] = 3'b000; modes[1] = 3'b001; modes[2] = 3'b011;
        modes[3] = 3'b111; modes[4] = 3'b010; modes[5] = 3'b101;

        rst_n = 1'b0;
        mode = 3'b000; song_num = '0; user = '0; finished = 1'b0; score = '0;
        rand_src();
        m_prev = 3'b000; view = V_IDLE; gap = 0; age = 0; fin_prev = 1'b0; blink = 1'b0;
        for (int i = 0; i < NU*NS; i++) tbl[i] = '0;

        #12;
        check_reset_state("reset");

        @(negedge clk);
        rst_n = 1'b1;
        user = 2'd0; song_num = 2'd0;

        // idle -> auto, song 2: gap then tracking
        mode = 3'b011; song_num = 2'd2;
        run(M + 15);

        // auto -> free -> auto within the gap: gap restarts
        mode = 3'b001; run(5);
        mode = 3'b011; run(M + 10);

        // free
        mode = 3'b001; run(M + 10);

        // learning, user 1 song 3
        user = 2'd1; song_num = 2'd3; finished = 1'b0;
        mode = 3'b111; run(M + 3);
        score = SW'(500); finished = 1'b1; run(14);
        finished = 1'b0; run(2);
        score = SW'(300); finished = 1'b1; run(4);
        finished = 1'b0; run(2);
        score = SW'(500); finished = 1'b1; run(4);
        finished = 1'b0; run(2);
        // selection change while showing the result
        score = SW'(700); user = 2'd2; song_num = 2'd1; finished = 1'b1; run(3);
        user = 2'd3; song_num = 2'd0; run(3);
        finished = 1'b0; run(2);

        // finished already high when learning is entered
        score = SW'(900); finished = 1'b1;
        mode = 3'b001; run(M + 3);
        mode = 3'b111; run(M + 5);
        finished = 1'b0; run(2);
        finished = 1'b1; run(3);
        finished = 1'b0; run(2);

        // large score near the top of the range
        score = {1'b1, 32'hFFFF_FFF0}; finished = 1'b1; run(3);
        finished = 1'b0; run(2);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 59) == 0) mode = modes[$urandom_range(0, 5)];
            if ($urandom_range(0, 5) == 0) finished = ~finished;
            if ($urandom_range(0, 9) == 0) begin
                user     = 2'($urandom);
                song_num = 2'($urandom);
            end
            if ($urandom_range(0, 3) == 0) score = SW'($urandom_range(0, 1000));
            rand_src();
            step();
        end

        // reset in the middle of an auto cycle with the source toggling
        mode = 3'b011; finished = 1'b0;
        run(M + 5);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_state("midreset");
        chk("queue_drained", 64'(q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
